// File: rtl/ext_mem_wb_responder.sv
// Wishbone classic single-transfer responder backed by a word-wide byte-writable RAM.
// Requests complete after WAIT_STATES extra cycles; dropping cyc/stb while waiting aborts.
// Optional macro EXT_MEM_RESP_ERR_EN: out-of-range accesses end with wb_err_o instead of
// aliasing into the array modulo DEPTH_WORDS.
module ext_mem_wb_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   output logic        wb_err_o
);

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SpanBytes = 32'(4 * DEPTH_WORDS);
   localparam logic [3:0]  CntInit   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wdat_q, wdat_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] rdat_q, rdat_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic          req;
   logic [31:0]   cur_adr;
   logic [31:0]   cur_wdat;
   logic          cur_we;
   logic [3:0]    cur_sel;
   logic [31:0]   offset;
   logic [AW-1:0] idx;
   logic          resp_err;
   logic          finish;
   logic          mem_we;

   assign req = wb_cyc_i & wb_stb_i;

   // With zero wait states the response edge is the accept edge, so use the live bus fields.
   always_comb begin
      cur_adr  = adr_q;
      cur_wdat = wdat_q;
      cur_we   = we_q;
      cur_sel  = sel_q;
      if (state_q == StIdle) begin
         cur_adr  = wb_adr_i;
         cur_wdat = wb_dat_i;
         cur_we   = wb_we_i;
         cur_sel  = wb_sel_i;
      end
   end

   assign offset = cur_adr - BASE_ADDR;
   assign idx    = offset[AW+1:2];

`ifdef EXT_MEM_RESP_ERR_EN
   assign resp_err = (offset >= SpanBytes);
`else
   // Out-of-range offsets simply alias; only the word-index bits matter.
   logic unused_offset_bits;
   assign unused_offset_bits = ^{offset, SpanBytes};
   assign resp_err           = 1'b0;
`endif

   // Next-state, capture and response generation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      we_d    = we_q;
      sel_d   = sel_q;
      rdat_d  = rdat_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      finish  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               adr_d  = wb_adr_i;
               wdat_d = wb_dat_i;
               we_d   = wb_we_i;
               sel_d  = wb_sel_i;
               if (WAIT_STATES == 0) begin
                  finish = 1'b1;
               end else begin
                  state_d = StWait;
                  cnt_d   = CntInit;
               end
            end
         end
         StWait: begin
            if (!req) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
               finish = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (finish) begin
         state_d = StResp;
         ack_d   = ~resp_err;
         err_d   = resp_err;
         if (resp_err) begin
            rdat_d = 32'h0;
         end else if (!cur_we) begin
            rdat_d = mem[idx];
         end
      end
   end

   assign mem_we = finish & cur_we & ~resp_err;

   // Control and response registers; reset takes effect immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         adr_q   <= 32'h0;
         wdat_q  <= 32'h0;
         we_q    <= 1'b0;
         sel_q   <= 4'h0;
         rdat_q  <= 32'h0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         rdat_q  <= rdat_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // Storage is never reset; enabled byte lanes commit on the edge entering RESP.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (cur_sel[b]) begin
               mem[idx][8*b +: 8] <= cur_wdat[8*b +: 8];
            end
         end
      end
   end

   assign wb_dat_o = rdat_q;
   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;

endmodule
